// File: rtl/mcb_if.sv
// MCB-style user port bundle: command, write-data and read-data FIFO channels.
// The master drives requests and the memory-side responder drives FIFO status and read data.
interface mcb_if;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_empty;
    logic        mem_cmd_full;

    logic        mem_wr_en;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;
    logic        mem_wr_full;
    logic        mem_wr_empty;
    logic [6:0]  mem_wr_count;
    logic        mem_wr_underrun;
    logic        mem_wr_error;

    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        mem_rd_full;
    logic        mem_rd_empty;
    logic [6:0]  mem_rd_count;
    logic        mem_rd_overflow;
    logic        mem_rd_error;

    modport master (
        output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
        input  mem_cmd_empty, mem_cmd_full,
        output mem_wr_en, mem_wr_mask, mem_wr_data,
        input  mem_wr_full, mem_wr_empty, mem_wr_count, mem_wr_underrun, mem_wr_error,
        output mem_rd_en,
        input  mem_rd_data, mem_rd_full, mem_rd_empty, mem_rd_count, mem_rd_overflow, mem_rd_error
    );

    modport slave (
        input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
        output mem_cmd_empty, mem_cmd_full,
        input  mem_wr_en, mem_wr_mask, mem_wr_data,
        output mem_wr_full, mem_wr_empty, mem_wr_count, mem_wr_underrun, mem_wr_error,
        input  mem_rd_en,
        output mem_rd_data, mem_rd_full, mem_rd_empty, mem_rd_count, mem_rd_overflow, mem_rd_error
    );
endinterface

// File: rtl/mcb_bram_port.sv
// Memory-side responder for an MCB-style user port: executes cmd FIFO bursts against
// byte-lane block RAM, consuming the wr FIFO and filling a first-word-fall-through rd FIFO.
module mcb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok, pop_ok;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : store[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= bump(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= bump(rd_ptr_reg);
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr_reg] <= din;
    end
endmodule

module mcb_bram_port #(
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int CMD_DEPTH      = 4,
    parameter int DATA_DEPTH     = 64
) (
    input logic  clk,
    input logic  rst_n,
    mcb_if.slave bus
);
    localparam int AW    = MEM_WORDS_LOG2;
    localparam int CMD_W = 3 + 6 + AW;

    typedef enum logic [2:0] {IDLE, WRITE, READ, RD_DRAIN, REFRESH} state_t;
    state_t state_reg, state_next;

    logic [AW-1:0]    addr_reg;
    logic [6:0]       beats_reg;
    logic             rd_valid_reg;
    logic             wr_underrun_reg, wr_error_reg, rd_overflow_reg, rd_error_reg;
    logic [CMD_W-1:0] cmd_head;
    logic [2:0]       cmd_instr;
    logic [5:0]       cmd_bl;
    logic [AW-1:0]    cmd_addr;
    logic [35:0]      wr_head;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic             cmd_pop, wr_pop, bram_we, rd_issue, underrun_beat, beat;
    logic             wr_drop, rd_drop, rd_bad_pop;

    logic [$clog2(CMD_DEPTH + 1)-1:0] cmd_count_unused;
    logic                             addr_bits_unused;
    assign addr_bits_unused = &{1'b0, bus.mem_cmd_byte_addr[29:AW+2],
                                bus.mem_cmd_byte_addr[1:0], cmd_instr[1]};

    assign {cmd_instr, cmd_bl, cmd_addr} = cmd_head;
    assign {wr_mask, wr_data}            = wr_head;

    mcb_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.mem_cmd_en),
        .pop   (cmd_pop),
        .din   ({bus.mem_cmd_instr, bus.mem_cmd_bl, bus.mem_cmd_byte_addr[AW+1:2]}),
        .head  (cmd_head),
        .count (cmd_count_unused),
        .full  (bus.mem_cmd_full),
        .empty (bus.mem_cmd_empty)
    );

    mcb_fifo #(.WIDTH(36), .DEPTH(DATA_DEPTH), .CW(7)) u_wr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.mem_wr_en),
        .pop   (wr_pop),
        .din   ({bus.mem_wr_mask, bus.mem_wr_data}),
        .head  (wr_head),
        .count (bus.mem_wr_count),
        .full  (bus.mem_wr_full),
        .empty (bus.mem_wr_empty)
    );

    mcb_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH), .CW(7)) u_rd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_valid_reg),
        .pop   (bus.mem_rd_en),
        .din   (rd_word),
        .head  (bus.mem_rd_data),
        .count (bus.mem_rd_count),
        .full  (bus.mem_rd_full),
        .empty (bus.mem_rd_empty)
    );

    // One BRAM per byte lane keeps masked writes as plain single-port writes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [2**AW];
        logic [7:0] rd_byte_reg;
        always_ff @(posedge clk) begin
            if (bram_we && !wr_mask[gi]) lane_mem[addr_reg] <= wr_data[8*gi +: 8];
            rd_byte_reg <= lane_mem[addr_reg];
        end
        assign rd_word[8*gi +: 8] = rd_byte_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!bus.mem_cmd_empty) begin
                    if (cmd_instr[2])      state_next = REFRESH;
                    else if (cmd_instr[0]) state_next = READ;
                    else                   state_next = WRITE;
                end
            end
            WRITE:    if (beats_reg == 7'd1) state_next = IDLE;
            READ:     if (beats_reg == 7'd1) state_next = RD_DRAIN;
            RD_DRAIN: state_next = IDLE;
            REFRESH:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_pop       = 1'b0;
        wr_pop        = 1'b0;
        bram_we       = 1'b0;
        rd_issue      = 1'b0;
        underrun_beat = 1'b0;
        beat          = 1'b0;
        case (state_reg)
            IDLE: cmd_pop = !bus.mem_cmd_empty;
            WRITE: begin
                // An empty wr FIFO still burns the beat so the engine never stalls.
                beat          = 1'b1;
                wr_pop        = !bus.mem_wr_empty;
                bram_we       = !bus.mem_wr_empty;
                underrun_beat = bus.mem_wr_empty;
            end
            READ: begin
                beat     = 1'b1;
                rd_issue = 1'b1;
            end
            default: ;
        endcase
    end

    assign wr_drop    = bus.mem_wr_en && bus.mem_wr_full && !wr_pop;
    assign rd_bad_pop = bus.mem_rd_en && bus.mem_rd_empty;
    assign rd_drop    = rd_valid_reg && bus.mem_rd_full && !(bus.mem_rd_en && !bus.mem_rd_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg        <= '0;
            beats_reg       <= '0;
            rd_valid_reg    <= 1'b0;
            wr_underrun_reg <= 1'b0;
            wr_error_reg    <= 1'b0;
            rd_overflow_reg <= 1'b0;
            rd_error_reg    <= 1'b0;
        end else begin
            if (cmd_pop) begin
                addr_reg  <= cmd_addr;
                beats_reg <= {1'b0, cmd_bl} + 7'd1;
            end else if (beat) begin
                addr_reg  <= addr_reg + 1'b1;
                beats_reg <= beats_reg - 7'd1;
            end
            rd_valid_reg <= rd_issue;
            if (underrun_beat)           wr_underrun_reg <= 1'b1;
            if (underrun_beat || wr_drop) wr_error_reg   <= 1'b1;
            if (rd_drop)                 rd_overflow_reg <= 1'b1;
            if (rd_drop || rd_bad_pop)   rd_error_reg    <= 1'b1;
        end
    end

    assign bus.mem_wr_underrun = wr_underrun_reg;
    assign bus.mem_wr_error    = wr_error_reg;
    assign bus.mem_rd_overflow = rd_overflow_reg;
    assign bus.mem_rd_error    = rd_error_reg;
endmodule

// File: tb/tb_mcb_bram_port.sv
// Scoreboard bench for mcb_bram_port: a word model predicts read data, which is queued at
// command issue and compared as words are popped from the read FIFO.
module tb_mcb_bram_port;
    localparam int WORDS = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    mcb_if bus();

    mcb_bram_port #(.MEM_WORDS_LOG2(12), .CMD_DEPTH(4), .DATA_DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    logic [31:0] pend_data [$];
    logic [3:0]  pend_mask [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] data, input logic [3:0] mask);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = data;
        bus.mem_wr_mask = mask;
        tick();
        bus.mem_wr_en = 1'b0;
        pend_data.push_back(data);
        pend_mask.push_back(mask);
    endtask

    // Returns one time unit after the edge that samples the command.
    task automatic issue(input logic [2:0] instr, input int bl, input int word);
        bus.mem_cmd_en        = 1'b1;
        bus.mem_cmd_instr     = instr;
        bus.mem_cmd_bl        = 6'(bl);
        bus.mem_cmd_byte_addr = 30'(word * 4);
        tick();
        bus.mem_cmd_en = 1'b0;
        $display("cmd instr=%0d bl=%0d word=%0d", instr, bl, word);
    endtask

    task automatic write_cmd(input int bl, input int word);
        for (int b = 0; b <= bl; b++) begin
            if (pend_data.size() > 0) begin
                logic [31:0] d;
                logic [3:0]  m;
                logic [31:0] w;
                int          a;
                d = pend_data.pop_front();
                m = pend_mask.pop_front();
                a = (word + b) % WORDS;
                w = model.exists(a) ? model[a] : 32'h0;
                for (int i = 0; i < 4; i++) if (!m[i]) w[8*i +: 8] = d[8*i +: 8];
                model[a] = w;
            end
        end
        issue(3'b000, bl, word);
    endtask

    task automatic read_cmd(input int bl, input int word, input bit keep);
        if (keep)
            for (int b = 0; b <= bl; b++) exp_q.push_back(model[(word + b) % WORDS]);
        issue(3'b001, bl, word);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.mem_cmd_empty && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (!bus.mem_cmd_empty) begin
            n_fail++;
            $display("FAIL wait_idle: cmd_empty=%0b after %0d cycles, required 1", bus.mem_cmd_empty, n);
        end
        repeat (70) tick();
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            int          n;
            n = 0;
            while (bus.mem_rd_empty && n < 20) begin
                tick();
                n++;
            end
            e = exp_q.pop_front();
            n_checks++;
            if (bus.mem_rd_empty) begin
                n_fail++;
                $display("FAIL rd_timeout: rd_empty=1 with %0d words outstanding, required data %h", exp_q.size() + 1, e);
                exp_q.delete();
            end else begin
                if (bus.mem_rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h, required %h", bus.mem_rd_data, e);
                end else begin
                    $display("rd pop data=%h", bus.mem_rd_data);
                end
                bus.mem_rd_en = 1'b1;
                tick();
                bus.mem_rd_en = 1'b0;
            end
        end
        n_checks++;
        if (bus.mem_rd_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_empty_after_drain: got %b, required 1", bus.mem_rd_empty);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_cmd_empty, bus.mem_wr_empty, bus.mem_rd_empty} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_empties: got %b, required 111", {bus.mem_cmd_empty, bus.mem_wr_empty, bus.mem_rd_empty});
        end
        n_checks++;
        if ({bus.mem_cmd_full, bus.mem_wr_full, bus.mem_rd_full, bus.mem_wr_underrun, bus.mem_wr_error,
             bus.mem_rd_overflow, bus.mem_rd_error, bus.mem_wr_count, bus.mem_rd_count, bus.mem_rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: full=%b%b%b err=%b%b%b%b counts=%0d/%0d rd_data=%h, required all 0",
                     bus.mem_cmd_full, bus.mem_wr_full, bus.mem_rd_full, bus.mem_wr_underrun, bus.mem_wr_error,
                     bus.mem_rd_overflow, bus.mem_rd_error, bus.mem_wr_count, bus.mem_rd_count, bus.mem_rd_data);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_write_read();
        push_wr(32'h11223344, 4'b0000);
        write_cmd(0, 16);
        wait_idle();
        read_cmd(0, 16, 1'b1);
        n_checks++;
        if ({bus.mem_cmd_empty, bus.mem_rd_empty} !== 2'b01) begin
            n_fail++;
            $display("FAIL lat_e0: cmd_empty,rd_empty=%b, required 01", {bus.mem_cmd_empty, bus.mem_rd_empty});
        end
        tick();
        n_checks++;
        if ({bus.mem_cmd_empty, bus.mem_rd_empty} !== 2'b11) begin
            n_fail++;
            $display("FAIL lat_e1: cmd_empty,rd_empty=%b, required 11", {bus.mem_cmd_empty, bus.mem_rd_empty});
        end
        tick();
        n_checks++;
        if (bus.mem_rd_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_e2: rd_empty=%b, required 1", bus.mem_rd_empty);
        end
        tick();
        n_checks++;
        if (bus.mem_rd_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_e3: rd_empty=%b, required 0", bus.mem_rd_empty);
        end
        drain();
    endtask

    task automatic test_mask();
        issue(3'b100, 0, 0);
        push_wr(32'hAABBCCDD, 4'b1100);
        write_cmd(0, 16);
        wait_idle();
        n_checks++;
        if (model[16] !== 32'h1122CCDD) begin
            n_fail++;
            $display("FAIL mask_model: got %h, required 1122ccdd", model[16]);
        end
        read_cmd(0, 16, 1'b1);
        wait_idle();
        drain();
    endtask

    task automatic test_burst();
        for (int i = 0; i < 8; i++) push_wr(32'(i), 4'b0000);
        write_cmd(7, WORDS - 4);
        wait_idle();
        read_cmd(7, WORDS - 4, 1'b1);
        wait_idle();
        n_checks++;
        if (bus.mem_rd_count !== 7'd8) begin
            n_fail++;
            $display("FAIL burst_rd_count: got %0d, required 8", bus.mem_rd_count);
        end
        drain();
        read_cmd(0, 0, 1'b1);
        wait_idle();
        drain();
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 4; i++) push_wr(32'hA0A0_0000 + 32'(i), 4'b0000);
        write_cmd(3, 32);
        wait_idle();
        n_checks++;
        if ({bus.mem_wr_underrun, bus.mem_wr_error} !== 2'b00) begin
            n_fail++;
            $display("FAIL pre_underrun_flags: got %b, required 00", {bus.mem_wr_underrun, bus.mem_wr_error});
        end
        push_wr(32'hB0B0_0000, 4'b0000);
        push_wr(32'hB0B0_0001, 4'b0000);
        write_cmd(3, 32);
        wait_idle();
        n_checks++;
        if ({bus.mem_wr_underrun, bus.mem_wr_error} !== 2'b11) begin
            n_fail++;
            $display("FAIL underrun_flags: got %b, required 11", {bus.mem_wr_underrun, bus.mem_wr_error});
        end
        read_cmd(3, 32, 1'b1);
        wait_idle();
        drain();
        n_checks++;
        if ({bus.mem_wr_underrun, bus.mem_wr_error} !== 2'b11) begin
            n_fail++;
            $display("FAIL underrun_sticky: got %b, required 11", {bus.mem_wr_underrun, bus.mem_wr_error});
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 64; i++) push_wr($urandom, 4'b0000);
        n_checks++;
        if ({bus.mem_wr_full, bus.mem_wr_count} !== {1'b1, 7'd64}) begin
            n_fail++;
            $display("FAIL wr_full: full=%b count=%0d, required 1/64", bus.mem_wr_full, bus.mem_wr_count);
        end
        write_cmd(63, 256);
        wait_idle();
        n_checks++;
        if (bus.mem_rd_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_overflow: got %b, required 0", bus.mem_rd_overflow);
        end
        read_cmd(63, 256, 1'b1);
        read_cmd(63, 256, 1'b0);
        wait_idle();
        n_checks++;
        if ({bus.mem_rd_full, bus.mem_rd_count, bus.mem_rd_overflow, bus.mem_rd_error} !== {1'b1, 7'd64, 2'b11}) begin
            n_fail++;
            $display("FAIL overflow: full=%b count=%0d ovf=%b err=%b, required 1/64/1/1",
                     bus.mem_rd_full, bus.mem_rd_count, bus.mem_rd_overflow, bus.mem_rd_error);
        end
        drain();
    endtask

    task automatic test_async_reset();
        read_cmd(63, 256, 1'b0);
        repeat (10) tick();
        n_checks++;
        if (bus.mem_rd_count == 7'd0) begin
            n_fail++;
            $display("FAIL midburst_count: got %0d, required nonzero", bus.mem_rd_count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_rd_empty, bus.mem_rd_count, bus.mem_rd_data, bus.mem_wr_underrun, bus.mem_wr_error,
             bus.mem_rd_overflow, bus.mem_rd_error, bus.mem_rd_full} !== {1'b1, 7'd0, 32'd0, 5'd0}) begin
            n_fail++;
            $display("FAIL async_reset: empty=%b count=%0d data=%h flags=%b%b%b%b full=%b, required 1/0/0/0000/0",
                     bus.mem_rd_empty, bus.mem_rd_count, bus.mem_rd_data, bus.mem_wr_underrun, bus.mem_wr_error,
                     bus.mem_rd_overflow, bus.mem_rd_error, bus.mem_rd_full);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        n_checks++;
        if ({bus.mem_rd_empty, bus.mem_cmd_empty} !== 2'b11) begin
            n_fail++;
            $display("FAIL burst_aborted: rd_empty,cmd_empty=%b, required 11", {bus.mem_rd_empty, bus.mem_cmd_empty});
        end
        bus.mem_rd_en = 1'b1;
        tick();
        bus.mem_rd_en = 1'b0;
        n_checks++;
        if ({bus.mem_rd_error, bus.mem_rd_count, bus.mem_wr_error} !== {1'b1, 7'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL pop_empty: rd_error=%b count=%0d wr_error=%b, required 1/0/0",
                     bus.mem_rd_error, bus.mem_rd_count, bus.mem_wr_error);
        end
    endtask

    initial begin
        bus.mem_cmd_en        = 1'b0;
        bus.mem_cmd_instr     = 3'b000;
        bus.mem_cmd_bl        = 6'd0;
        bus.mem_cmd_byte_addr = 30'd0;
        bus.mem_wr_en         = 1'b0;
        bus.mem_wr_mask       = 4'b0000;
        bus.mem_wr_data       = 32'd0;
        bus.mem_rd_en         = 1'b0;
        test_reset();
        test_write_read();
        test_mask();
        test_burst();
        test_underrun();
        test_overflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
